instr_sequencer: RTL and testbench

Central control FSM of the RISC CPU core. It sits directly downstream of the instruction register. It consumes the 3-bit opcode (IR bits [15:13]) and the accumulator zero flag, and emits the per-cycle strobes that drive the rest of the datapath:
- IR load, PC increment and load, memory read and write, accumulator load, data-bus drive
- halt

Every instruction runs a fixed 8-cycle sequence S0–S7.

---
 rtl/instr_sequencer.sv | 131 +++++++++++++
 tb/tb_instr_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Central control FSM: fixed 8-cycle S0..S7 instruction sequence decoded into datapath strobes.
// Optional ISEQ_STICKY_HALT_EN: HLT parks in a HALT state until resume or rst.
module instr_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_en,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       resume,
  output logic       load_ir,
  output logic       rd,
  output logic       wr,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       datactl_ena,
  output logic       halt
);

  localparam logic [3:0] S0   = 4'd0;
  localparam logic [3:0] S1   = 4'd1;
  localparam logic [3:0] S2   = 4'd2;
  localparam logic [3:0] S3   = 4'd3;
  localparam logic [3:0] S4   = 4'd4;
  localparam logic [3:0] S5   = 4'd5;
  localparam logic [3:0] S6   = 4'd6;
  localparam logic [3:0] S7   = 4'd7;
  localparam logic [3:0] HALT = 4'd8;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Strobe vector order: {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt}
  localparam logic [7:0] ST_FETCH = 8'b1101_0000;

  logic [3:0] state_q, state_d;
  logic       skip_q, skip_d;
  logic [7:0] strobe_c;
  logic       is_memop;

  assign is_memop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);

`ifndef ISEQ_STICKY_HALT_EN
  logic unused_resume;
  assign unused_resume = resume;
`endif

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    strobe_c = 8'b0;
    case (state_q)
      S0: begin
        if (fetch_en) begin
          strobe_c = ST_FETCH;
          state_d  = S1;
        end
      end
      S1: begin
        strobe_c = ST_FETCH;
        state_d  = S2;
      end
      S2: begin
        skip_d  = zero;
        state_d = S3;
      end
      S3: begin
        state_d = S4;
        if (is_memop)                      strobe_c[6] = 1'b1;
        if (opcode == OP_STO)              strobe_c[1] = 1'b1;
        if (opcode == OP_JMP)              strobe_c[3] = 1'b1;
        if ((opcode == OP_SKZ) && skip_q)  strobe_c[4] = 1'b1;
        if (opcode == OP_HLT) begin
          strobe_c[0] = 1'b1;
`ifdef ISEQ_STICKY_HALT_EN
          state_d = HALT;
`endif
        end
      end
      S4: begin
        state_d = S5;
        if (is_memop) begin
          strobe_c[6] = 1'b1;
          strobe_c[2] = 1'b1;
        end
        if (opcode == OP_STO) begin
          strobe_c[1] = 1'b1;
          strobe_c[5] = 1'b1;
        end
        if (opcode == OP_JMP)              strobe_c[3] = 1'b1;
        if ((opcode == OP_SKZ) && skip_q)  strobe_c[4] = 1'b1;
      end
      S5: begin
        state_d = S6;
        if (opcode == OP_STO) strobe_c[1] = 1'b1;
      end
      S6: state_d = S7;
      S7: state_d = S0;
`ifdef ISEQ_STICKY_HALT_EN
      HALT: begin
        // resume drops halt in the same cycle; S0 follows on the next edge
        strobe_c[0] = ~resume;
        if (resume) state_d = S0;
      end
`endif
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // rst forces every strobe low in the same cycle, aborting any write in flight
  assign {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt} =
    rst ? 8'b0 : strobe_c;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: driver pushes per-cycle expected strobes,
// a negedge monitor pops and compares them.
module tb_instr_sequencer;

  logic       clk;
  logic       rst;
  logic       fetch_en;
  logic [2:0] opcode;
  logic       zero;
  logic       resume;
  logic       load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt}
  localparam logic [7:0] E_NONE  = 8'b0000_0000;
  localparam logic [7:0] E_FETCH = 8'b1101_0000;
  localparam logic [7:0] E_RD    = 8'b0100_0000;
  localparam logic [7:0] E_RDACC = 8'b0100_0100;
  localparam logic [7:0] E_DEN   = 8'b0000_0010;
  localparam logic [7:0] E_WRDEN = 8'b0010_0010;
  localparam logic [7:0] E_LPC   = 8'b0000_1000;
  localparam logic [7:0] E_INC   = 8'b0001_0000;
  localparam logic [7:0] E_HALT  = 8'b0000_0001;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .opcode(opcode), .zero(zero),
    .resume(resume), .load_ir(load_ir), .rd(rd), .wr(wr), .inc_pc(inc_pc),
    .load_pc(load_pc), .load_acc(load_acc), .datactl_ena(datactl_ena), .halt(halt)
  );

  // Clock / reset: clk starts high so the first negedge samples the first driven cycle
  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e, act;
      string      t;
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      act = {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %b expected %b", t, act, e);
      end
    end
  end

  // Driver tasks
  task automatic cyc(input logic fe, input logic [2:0] op, input logic z,
                     input logic r, input logic res, input logic [7:0] e,
                     input string tag);
    fetch_en = fe;
    opcode   = op;
    zero     = z;
    rst      = r;
    resume   = res;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic memop(input logic [2:0] op, input string name);
    logic [7:0] pat [8];
    pat = '{E_FETCH, E_FETCH, E_NONE, E_RD, E_RDACC, E_NONE, E_NONE, E_NONE};
    for (int k = 0; k < 8; k++)
      cyc(k == 0, op, 1'b0, 1'b0, 1'b0, pat[k], $sformatf("%s c%0d", name, k));
  endtask

  initial begin
    logic [7:0] pat [8];
    fetch_en = 1'b0; opcode = OP_HLT; zero = 1'b0; rst = 1'b1; resume = 1'b0;

    // Reset (fetch_en high to prove rst masks the S0 fetch decode), then idle
    for (int k = 0; k < 2; k++) cyc(1'b1, OP_LDA, 1'b0, 1'b1, 1'b1, E_NONE, $sformatf("reset c%0d", k));
    for (int k = 0; k < 5; k++) cyc(1'b0, OP_LDA, 1'b0, 1'b0, 1'b0, E_NONE, $sformatf("idle c%0d", k));

    memop(OP_LDA, "lda");
    cyc(1'b0, OP_LDA, 1'b0, 1'b0, 1'b0, E_NONE, "lda c8 idle");

    // SKZ taken: zero=1 at S2, zero=0 afterwards must not matter
    pat = '{E_FETCH, E_FETCH, E_NONE, E_INC, E_INC, E_NONE, E_NONE, E_NONE};
    for (int k = 0; k < 8; k++)
      cyc(k == 0, OP_SKZ, k == 2, 1'b0, 1'b0, pat[k], $sformatf("skz1 c%0d", k));
    // SKZ not taken: zero=0 at S2, zero=1 later is ignored
    pat = '{E_FETCH, E_FETCH, E_NONE, E_NONE, E_NONE, E_NONE, E_NONE, E_NONE};
    for (int k = 0; k < 8; k++)
      cyc(k == 0, OP_SKZ, k >= 3, 1'b0, 1'b0, pat[k], $sformatf("skz0 c%0d", k));

    pat = '{E_FETCH, E_FETCH, E_NONE, E_DEN, E_WRDEN, E_DEN, E_NONE, E_NONE};
    for (int k = 0; k < 8; k++)
      cyc(k == 0, OP_STO, 1'b0, 1'b0, 1'b0, pat[k], $sformatf("sto c%0d", k));

    // STO aborted by rst in S4; S5's datactl_ena must not appear afterwards
    for (int k = 0; k < 4; k++)
      cyc(k == 0, OP_STO, 1'b0, 1'b0, 1'b0, pat[k], $sformatf("sto_rst c%0d", k));
    cyc(1'b0, OP_STO, 1'b0, 1'b1, 1'b0, E_NONE, "sto_rst c4 rst");
    cyc(1'b0, OP_STO, 1'b0, 1'b0, 1'b0, E_NONE, "sto_rst c5");
    cyc(1'b0, OP_STO, 1'b0, 1'b0, 1'b0, E_NONE, "sto_rst c6");
    memop(OP_ADD, "add_after_rst");

    // JMP then ADD back to back with fetch_en held high
    pat = '{E_FETCH, E_FETCH, E_NONE, E_LPC, E_LPC, E_NONE, E_NONE, E_NONE};
    for (int k = 0; k < 8; k++)
      cyc(1'b1, OP_JMP, 1'b0, 1'b0, 1'b0, pat[k], $sformatf("jmp c%0d", k));
    pat = '{E_FETCH, E_FETCH, E_NONE, E_RD, E_RDACC, E_NONE, E_NONE, E_NONE};
    for (int k = 0; k < 8; k++)
      cyc(k == 0, OP_ADD, 1'b0, 1'b0, 1'b0, pat[k], $sformatf("jmp_add c%0d", k + 8));

    memop(OP_AND, "and");
    memop(OP_XOR, "xor");

    // HLT
    pat = '{E_FETCH, E_FETCH, E_NONE, E_HALT, E_NONE, E_NONE, E_NONE, E_NONE};
    for (int k = 0; k < 4; k++)
      cyc(k == 0, OP_HLT, 1'b0, 1'b0, 1'b0, pat[k], $sformatf("hlt c%0d", k));
`ifdef ISEQ_STICKY_HALT_EN
    for (int k = 4; k < 20; k++)
      cyc(1'b1, OP_HLT, 1'b0, 1'b0, 1'b0, E_HALT, $sformatf("hlt c%0d", k));
    cyc(1'b0, OP_HLT, 1'b0, 1'b0, 1'b1, E_NONE, "hlt c20 resume");
    memop(OP_LDA, "lda_after_resume");
    // Reset out of HALT, with resume asserted alongside rst
    for (int k = 0; k < 4; k++)
      cyc(k == 0, OP_HLT, 1'b0, 1'b0, 1'b0, pat[k], $sformatf("hlt2 c%0d", k));
    cyc(1'b0, OP_HLT, 1'b0, 1'b0, 1'b0, E_HALT, "hlt2 c4");
    cyc(1'b0, OP_HLT, 1'b0, 1'b1, 1'b1, E_NONE, "hlt2 c5 rst");
    cyc(1'b0, OP_HLT, 1'b0, 1'b0, 1'b0, E_NONE, "hlt2 c6");
    cyc(1'b0, OP_HLT, 1'b0, 1'b0, 1'b0, E_NONE, "hlt2 c7");
`else
    for (int k = 4; k < 8; k++)
      cyc(1'b1, OP_HLT, 1'b0, 1'b0, 1'b1, pat[k], $sformatf("hlt c%0d", k));
    memop(OP_LDA, "lda_after_hlt");
`endif
    cyc(1'b0, OP_LDA, 1'b0, 1'b0, 1'b0, E_NONE, "final idle");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
